// File: rtl/shifter_pkg.sv
// Shared definitions for the Shifter datapath: FSM encoding and a constant
// clog2 so count widths are derived the same way in every block.
package shifter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_shifter_if.sv
// Load handshake between a word source (master) and the serial shifter (slave).
interface serial_shifter_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic [CNT_W-1:0] load_count;

   modport master (output load_valid, load_data, load_count, input load_ready);
   modport slave  (input load_valid, load_data, load_count, output load_ready);
endinterface

// File: rtl/serial_shifter.sv
// Parallel-in/serial-out shifter: shifts one bit per shift_en-high edge and
// pulses done for one cycle after the programmed number of bits has left.
module serial_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CNT_W     = clog2(WIDTH + 1),
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   serial_shifter_if.slave  ld,
   input  logic             shift_en,
   output logic             sdata,
   output logic             sdata_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   state_e           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_sh;
   logic [CNT_W-1:0] count_clamped;
   logic             out_bit;

   assign count_clamped = (ld.load_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : ld.load_count;

   always_comb begin
      shreg_sh = '0;
      out_bit  = 1'b0;
      if (MSB_FIRST) begin
         shreg_sh = {shreg[WIDTH-2:0], 1'b0};
         out_bit  = shreg[WIDTH-1];
      end else begin
         shreg_sh = {1'b0, shreg[WIDTH-1:1]};
         out_bit  = shreg[0];
      end
   end

   // state register plus the datapath it qualifies
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         remaining <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (ld.load_valid) begin
                  shreg     <= ld.load_data;
                  remaining <= count_clamped;
               end
            end
            ST_SHIFT: begin
               if (shift_en && (remaining != '0)) begin
                  shreg     <= shreg_sh;
                  remaining <= remaining - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (ld.load_valid)
               state_nxt = (count_clamped == '0) ? ST_DONE : ST_SHIFT;
         end
         ST_SHIFT: begin
            // remaining==0 is unreachable here; treat it as finished rather than stall
            if (remaining == '0 || (shift_en && remaining == CNT_W'(1)))
               state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ld.load_ready = 1'b0;
      sdata         = 1'b0;
      sdata_valid   = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state)
         ST_IDLE:  ld.load_ready = 1'b1;
         ST_SHIFT: begin
            sdata       = out_bit;
            sdata_valid = shift_en;
            busy        = 1'b1;
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_serial_shifter.sv
// Directed bench for serial_shifter: two instances (MSB-first and LSB-first)
// share stimulus; a queue of expected bits is filled at load time and drained per sdata_valid.
module tb_serial_shifter;
   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic reset;
   logic shift_en;
   always #5 clk = ~clk;

   serial_shifter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) li0 ();
   serial_shifter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) li1 ();

   assign li1.load_valid = li0.load_valid;
   assign li1.load_data  = li0.load_data;
   assign li1.load_count = li0.load_count;

   logic             sdata0, sv0, busy0, done0;
   logic             sdata1, sv1, busy1, done1;
   logic [CNT_W-1:0] rem0, rem1;

   serial_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .ld(li0.slave), .shift_en(shift_en),
      .sdata(sdata0), .sdata_valid(sv0), .busy(busy0), .done(done0), .remaining(rem0));

   serial_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .ld(li1.slave), .shift_en(shift_en),
      .sdata(sdata1), .sdata_valid(sv1), .busy(busy1), .done(done1), .remaining(rem1));

   bit               sel_dut;
   logic             o_sdata, o_sv, o_busy, o_done, o_ready;
   logic [CNT_W-1:0] o_rem;
   assign o_sdata = sel_dut ? sdata1 : sdata0;
   assign o_sv    = sel_dut ? sv1    : sv0;
   assign o_busy  = sel_dut ? busy1  : busy0;
   assign o_done  = sel_dut ? done1  : done0;
   assign o_rem   = sel_dut ? rem1   : rem0;
   assign o_ready = sel_dut ? li1.load_ready : li0.load_ready;

   int   total = 0;
   int   bad   = 0;
   logic sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ready"}, o_ready, 1);
      chk({tag, "_sdata"}, o_sdata, 0);
      chk({tag, "_sv"},    o_sv,    0);
      chk({tag, "_busy"},  o_busy,  0);
      chk({tag, "_done"},  o_done,  0);
      chk({tag, "_rem"},   o_rem,   0);
   endtask

   // Starts and ends in the low half of the clock. mode 0: shift_en always high,
   // mode 1: pattern 1,0,0 repeating. keep: hold load_valid with another word.
   task automatic xfer(input bit sel, input logic [7:0] d, input logic [3:0] c,
                       input int mode, input bit keep);
      int nb, shifts, last;
      bit seen;
      logic b;
      nb = (c > 4'd8) ? 8 : int'(c);
      for (int i = 0; i < nb; i++) sb.push_back(sel ? d[i] : d[7-i]);
      sel_dut        = sel;
      li0.load_valid = 1'b1;
      li0.load_data  = d;
      li0.load_count = c;
      shift_en       = 1'b1;
      #1;
      chk("accept_ready", o_ready, 1);
      @(posedge clk) #1;
      if (keep) li0.load_data = 8'h3C;
      else      li0.load_valid = 1'b0;
      shifts = 0;
      last   = -1;
      seen   = 1'b0;
      for (int k = 0; k < 64 && !seen; k++) begin
         shift_en = (mode == 0) ? 1'b1 : (k % 3 == 0);
         @(negedge clk);
         chk("remaining", o_rem, nb - shifts);
         chk("busy", o_busy, 1);
         if (keep) chk("ready_low", o_ready, 0);
         if (o_done) begin
            seen = 1'b1;
            chk("done_bits", shifts, nb);
            chk("done_lat", k, last + 1);
            chk("done_sv", o_sv, 0);
            chk("done_sdata", o_sdata, 0);
         end else begin
            chk("sv", o_sv, shift_en);
            if (sb.size() == 0) chk("overrun", sb.size(), 1);
            else begin
               chk("sdata", o_sdata, sb[0]);
               if (o_sv) begin
                  b = sb.pop_front();
                  shifts++;
                  last = k;
               end
            end
            @(posedge clk) #1;
         end
      end
      chk("done_seen", seen, 1);
      @(negedge clk);
      chk("post_ready", o_ready, 1);
      chk("post_done", o_done, 0);
      chk("post_busy", o_busy, 0);
      sb.delete();
   endtask

   initial begin
      sel_dut        = 1'b0;
      reset          = 1'b1;
      shift_en       = 1'b0;
      li0.load_valid = 1'b0;
      li0.load_data  = '0;
      li0.load_count = '0;
      #3;
      chk_reset_outs("rst");
      // load_valid during reset must not matter
      li0.load_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_outs("rst_hold");
      li0.load_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk_reset_outs("idle");

      xfer(1'b0, 8'hA5, 4'd8, 0, 1'b0);
      xfer(1'b0, 8'hA5, 4'd8, 1, 1'b0);
      xfer(1'b1, 8'h0F, 4'd4, 0, 1'b0);
      xfer(1'b0, 8'hFF, 4'd0, 0, 1'b0);
      xfer(1'b0, 8'hC3, 4'd12, 0, 1'b0);
      xfer(1'b1, 8'h96, 4'd5, 1, 1'b0);

      // abort after three bits
      sel_dut        = 1'b0;
      li0.load_valid = 1'b1;
      li0.load_data  = 8'hA5;
      li0.load_count = 4'd8;
      shift_en       = 1'b1;
      @(posedge clk) #1;
      li0.load_valid = 1'b0;
      @(negedge clk); chk("abort_b0", o_sdata, 1);
      @(negedge clk); chk("abort_b1", o_sdata, 0);
      @(negedge clk); chk("abort_b2", o_sdata, 1);
      chk("abort_rem", o_rem, 6);
      reset = 1'b1;
      #1;
      chk_reset_outs("abort");
      repeat (2) begin
         @(negedge clk);
         chk("abort_nodone", o_done, 0);
      end
      reset = 1'b0;
      xfer(1'b0, 8'h5A, 4'd8, 0, 1'b0);

      // load_valid held with a new word during SHIFT; picked up only after done
      xfer(1'b0, 8'hA5, 4'd8, 0, 1'b1);
      xfer(1'b0, 8'h3C, 4'd8, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end
endmodule
